ogr_frame_sequencer: RTL
========================

OGR_FRAME_SEQUENCER -- requirements
Module: ogr_frame_sequencer

Interface
REQ-001 SHALL have parameter IN_BYTES, default 6, command frame length in bytes (48 bits).
REQ-002 SHALL have parameter OUT_BYTES, default 8, result frame length in bytes (64 bits).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 120000, inter-byte receive timeout (10 ms at 12 MHz).
REQ-004 Ports SHALL be:
- iCE_CLK  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle pulse from UART "received".
- rx_data  in  8  UART received byte, valid with rx_valid.
- tx_busy  in  1  UART "is_transmitting".
- tx_start  out  1  one-cycle transmit request to UART.
- tx_data  out  8  byte to transmit, stable from tx_start until tx_busy rises.
- core_start  out  1  one-cycle start pulse to compute core.
- core_operands  out  8*IN_BYTES  assembled command frame, held stable from core_start until core_done.
- core_done  in  1  one-cycle pulse; core_result valid in the same cycle.
- core_result  in  8*OUT_BYTES  result frame from core.
- clear_err  in  1  clears sticky error flags.
- busy  out  1  high whenever state is not IDLE.
- err_timeout  out  1  sticky: partial frame discarded on timeout.
- err_overrun  out  1  sticky: byte received while unable to accept.
- frame_count  out  8  number of completed result frames, wraps 255->0.

Function
REQ-005 States SHALL be IDLE, RECV, START, WAIT_CORE, SEND_LOAD, SEND_ACK, SEND_DRAIN.
REQ-006 IDLE: on rx_valid SHALL store rx_data in operand byte 0, set byte index to 1, go to RECV (or START if IN_BYTES=1).
REQ-007 Byte k SHALL occupy core_operands[8*(IN_BYTES-k)-1 -: 8]; byte 0 is the MSB byte.
REQ-008 RECV: on rx_valid SHALL store byte at current index and increment it; after the byte at index IN_BYTES-1 is stored, go to START.
REQ-009 RECV: timeout counter SHALL reset on every accepted byte; once it reaches TIMEOUT_CYCLES-1 with no rx_valid, SHALL discard the partial frame, set err_timeout, go to IDLE.
REQ-010 rx_valid and timeout expiry in the same cycle: the byte SHALL be accepted and no timeout recorded.
REQ-011 START: SHALL assert core_start for exactly one cycle, then go to WAIT_CORE; core_start is high the cycle after the last byte is captured.
REQ-012 WAIT_CORE: on core_done SHALL register core_result into an output shift register, reset byte index to 0, go to SEND_LOAD; core_done in any other state SHALL be ignored.
REQ-013 SEND_LOAD: when tx_busy is low SHALL drive tx_data with result byte at index (byte 0 = core_result MSB byte), pulse tx_start one cycle, go to SEND_ACK.
REQ-014 SEND_ACK: SHALL wait for tx_busy high, then go to SEND_DRAIN; tx_start SHALL not be re-asserted meanwhile.
REQ-015 SEND_DRAIN: on tx_busy low SHALL increment byte index; if OUT_BYTES bytes sent, increment frame_count and go to IDLE, else go to SEND_LOAD.
REQ-016 rx_valid in START, WAIT_CORE, or any SEND state SHALL drop the byte and set err_overrun; operands SHALL remain unchanged.
REQ-017 clear_err high SHALL clear both sticky flags the next edge; a simultaneous setting event SHALL take priority (flag stays set).
REQ-018 Byte index and timeout counters SHALL be sized by $clog2 of their limits; no overflow beyond limit is permitted.
REQ-019 Latency from core_done to first tx_start SHALL be 2 cycles when tx_busy is low.

Reset
REQ-020 rst_n low SHALL immediately force state IDLE, tx_start=0, tx_data=0, core_start=0, core_operands=0, busy=0, err_timeout=0, err_overrun=0, frame_count=0, all counters 0.
REQ-021 Reset asserted mid-frame or mid-send SHALL abandon the operation; no further tx_start or core_start until a new full frame is received.
REQ-022 Release of rst_n SHALL be synchronised internally so that the first state change occurs on a clean clock edge.

Verification
REQ-023 Bytes 01 02 03 04 05 06 -> core_operands=48'h010203040506, single core_start pulse one cycle after sixth byte.
REQ-024 core_done with core_result=64'h0102_0000_0304_0506 and UART model -> tx bytes 01 02 00 00 03 04 05 06 in order, one tx_start each, frame_count=1, busy=0.
REQ-025 Three bytes then TIMEOUT_CYCLES idle -> err_timeout=1, state IDLE, next six bytes form a fresh frame from byte 0.
REQ-026 rx_valid during WAIT_CORE -> err_overrun=1, core_operands unchanged; clear_err -> flag 0 next cycle.
REQ-027 rst_n low during SEND_DRAIN after byte 3 -> all outputs at reset values asynchronously; no further tx_start after release.

Source files
------------

// File: rtl/ogr_frame_sequencer.sv
// UART-to-compute-core frame sequencer: assembles an IN_BYTES command frame,
// runs the core once, then streams the OUT_BYTES result back MSB byte first.
module ogr_frame_sequencer #(
   parameter int IN_BYTES       = 6,
   parameter int OUT_BYTES      = 8,
   parameter int TIMEOUT_CYCLES = 120000
) (
   input  logic                   iCE_CLK,
   input  logic                   rst_n,
   input  logic                   rx_valid,
   input  logic [7:0]             rx_data,
   input  logic                   tx_busy,
   output logic                   tx_start,
   output logic [7:0]             tx_data,
   output logic                   core_start,
   output logic [8*IN_BYTES-1:0]  core_operands,
   input  logic                   core_done,
   input  logic [8*OUT_BYTES-1:0] core_result,
   input  logic                   clear_err,
   output logic                   busy,
   output logic                   err_timeout,
   output logic                   err_overrun,
   output logic [7:0]             frame_count
);

   localparam int RW = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;
   localparam int TW = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [RW-1:0] RX_LAST = RW'(IN_BYTES - 1);
   localparam logic [TW-1:0] TX_LAST = TW'(OUT_BYTES - 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [RW-1:0] RX_NEXT = (IN_BYTES > 1) ? RW'(1) : '0;

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_RECV       = 3'd1;
   localparam logic [2:0] S_START      = 3'd2;
   localparam logic [2:0] S_WAIT_CORE  = 3'd3;
   localparam logic [2:0] S_SEND_LOAD  = 3'd4;
   localparam logic [2:0] S_SEND_ACK   = 3'd5;
   localparam logic [2:0] S_SEND_DRAIN = 3'd6;

   logic [2:0]             state;
   logic [1:0]             rst_sync;
   logic                   run;
   logic [RW-1:0]          rx_idx;
   logic [TW-1:0]          tx_idx;
   logic [CW-1:0]          to_cnt;
   logic [8*OUT_BYTES-1:0] res_shift;
   logic [7:0]             op_bytes [IN_BYTES];

   // Reset asserts asynchronously but releases only after two clean edges.
   always_ff @(posedge iCE_CLK or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign run = rst_sync[1];

   genvar gi;
   generate
      for (gi = 0; gi < IN_BYTES; gi++) begin : g_op
         assign core_operands[8*(IN_BYTES-gi)-1 -: 8] = op_bytes[gi];
      end
   endgenerate

   assign core_start = (state == S_START);
   assign busy       = (state != S_IDLE);

   always_ff @(posedge iCE_CLK or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         rx_idx      <= '0;
         tx_idx      <= '0;
         to_cnt      <= '0;
         tx_start    <= 1'b0;
         tx_data     <= 8'h00;
         res_shift   <= '0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
         frame_count <= 8'h00;
         for (int i = 0; i < IN_BYTES; i++) op_bytes[i] <= 8'h00;
      end else if (run) begin
         tx_start <= 1'b0;
         if (clear_err) begin
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (rx_valid) begin
                  op_bytes[0] <= rx_data;
                  rx_idx      <= RX_NEXT;
                  to_cnt      <= '0;
                  state       <= (IN_BYTES == 1) ? S_START : S_RECV;
               end
            end
            S_RECV: begin
               // An arriving byte wins over a timeout expiring in the same cycle.
               if (rx_valid) begin
                  op_bytes[rx_idx] <= rx_data;
                  to_cnt           <= '0;
                  if (rx_idx == RX_LAST) begin
                     rx_idx <= '0;
                     state  <= S_START;
                  end else begin
                     rx_idx <= rx_idx + 1'b1;
                  end
               end else if (to_cnt == TO_LAST) begin
                  err_timeout <= 1'b1;
                  rx_idx      <= '0;
                  to_cnt      <= '0;
                  state       <= S_IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_START: state <= S_WAIT_CORE;
            S_WAIT_CORE: begin
               if (core_done) begin
                  res_shift <= core_result;
                  tx_idx    <= '0;
                  state     <= S_SEND_LOAD;
               end
            end
            S_SEND_LOAD: begin
               if (!tx_busy) begin
                  tx_data  <= res_shift[8*OUT_BYTES-1 -: 8];
                  tx_start <= 1'b1;
                  state    <= S_SEND_ACK;
               end
            end
            S_SEND_ACK: if (tx_busy) state <= S_SEND_DRAIN;
            S_SEND_DRAIN: begin
               if (!tx_busy) begin
                  res_shift <= res_shift << 8;
                  if (tx_idx == TX_LAST) begin
                     tx_idx      <= '0;
                     frame_count <= frame_count + 8'd1;
                     state       <= S_IDLE;
                  end else begin
                     tx_idx <= tx_idx + 1'b1;
                     state  <= S_SEND_LOAD;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
         if (rx_valid && (state != S_IDLE) && (state != S_RECV)) err_overrun <= 1'b1;
      end
   end

endmodule
